// File: rtl/inv_delay_meter.sv
// Measures inverter propagation delay in clk cycles for the output-falling and output-rising edges.
// Optional INVM_AVG_EN repeats the trial 2**LOG2_AVG times per start and reports the truncated mean.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start; results held
// SETTLE0 | stim low for SETTLE_CYC cycles, resp must be 1
// MEAS_F  | stim high, counting until resp_s falls
// SETTLE1 | stim held high for SETTLE_CYC cycles
// MEAS_R  | stim low, counting until resp_s rises
// DONE    | one-cycle done pulse
module inv_delay_meter #(
  parameter int CW         = 16,
  parameter int SETTLE_CYC = 8,
  parameter int MAX_CYC    = 1000,
  parameter int SYNC_STG   = 2,
  parameter int LOG2_AVG   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          resp,
  output logic          stim,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] delay_fall,
  output logic [CW-1:0] delay_rise,
  output logic          timeout,
  output logic          bad_init
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE0 = 3'd1;
  localparam logic [2:0] MEAS_F  = 3'd2;
  localparam logic [2:0] SETTLE1 = 3'd3;
  localparam logic [2:0] MEAS_R  = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam int TW = $clog2(SETTLE_CYC + 1);

  logic [2:0]          state, state_nxt;
  logic [SYNC_STG-1:0] sync_q;
  logic                resp_s;
  logic [TW-1:0]       tmr;
  logic                tmr_tc;
  logic [CW-1:0]       cnt, meas_val;
  logic                meas_exit, meas_tout, last_trial;

  generate
    if (SYNC_STG < 2 || LOG2_AVG < 1 || SETTLE_CYC < 1 || MAX_CYC >= 2**CW - 1) begin : g_param_chk
      $error("inv_delay_meter: illegal parameter combination");
    end
  endgenerate

  assign resp_s = sync_q[SYNC_STG-1];
  assign tmr_tc = (tmr == '0);

  always_comb begin
    state_nxt = state;
    meas_exit = 1'b0;
    meas_tout = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE0;
      SETTLE0: if (tmr_tc) state_nxt = MEAS_F;
      MEAS_F: begin
        if (!resp_s) meas_exit = 1'b1;
        else if (cnt == CW'(MAX_CYC)) begin
          meas_exit = 1'b1;
          meas_tout = 1'b1;
        end
        if (meas_exit) state_nxt = SETTLE1;
      end
      SETTLE1: if (tmr_tc) state_nxt = MEAS_R;
      MEAS_R: begin
        if (resp_s) meas_exit = 1'b1;
        else if (cnt == CW'(MAX_CYC)) begin
          meas_exit = 1'b1;
          meas_tout = 1'b1;
        end
        if (meas_exit) state_nxt = last_trial ? DONE : SETTLE0;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt is 1 in the launch cycle; the synchronizer latency is removed here
  always_comb begin
    if (meas_tout) meas_val = '1;
    else if (cnt > CW'(SYNC_STG)) meas_val = cnt - CW'(SYNC_STG);
    else meas_val = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sync_q   <= '0;
      stim     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tmr      <= '0;
      cnt      <= '0;
      timeout  <= 1'b0;
      bad_init <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], resp};
      state  <= state_nxt;
      stim   <= (state_nxt == MEAS_F) || (state_nxt == SETTLE1);
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
      if (state_nxt != state) begin
        tmr <= TW'(SETTLE_CYC - 1);
        cnt <= CW'(1);
      end else begin
        if (!tmr_tc) tmr <= tmr - TW'(1);
        if (state == MEAS_F || state == MEAS_R) cnt <= cnt + CW'(1);
      end
      if (state == IDLE && start) begin
        timeout  <= 1'b0;
        bad_init <= 1'b0;
      end
      if (state == SETTLE0 && tmr_tc && !resp_s) bad_init <= 1'b1;
      if (meas_tout) timeout <= 1'b1;
    end
  end

`ifdef INVM_AVG_EN
  localparam int AW = CW + LOG2_AVG;

  logic [LOG2_AVG-1:0] trial;
  logic [AW-1:0]       sum_f, sum_r, sum_nxt;
  logic                tout_f, tout_r;

  assign last_trial = &trial;
  assign sum_nxt    = ((state == MEAS_R) ? sum_r : sum_f) + AW'(meas_val);

  // a single timed-out trial poisons that edge's mean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trial      <= '0;
      sum_f      <= '0;
      sum_r      <= '0;
      tout_f     <= 1'b0;
      tout_r     <= 1'b0;
      delay_fall <= '0;
      delay_rise <= '0;
    end else if (state == IDLE && start) begin
      trial  <= '0;
      sum_f  <= '0;
      sum_r  <= '0;
      tout_f <= 1'b0;
      tout_r <= 1'b0;
    end else if (meas_exit && state == MEAS_F) begin
      if (last_trial) delay_fall <= (tout_f || meas_tout) ? '1 : CW'(sum_nxt >> LOG2_AVG);
      sum_f  <= sum_nxt;
      tout_f <= tout_f | meas_tout;
    end else if (meas_exit && state == MEAS_R) begin
      if (last_trial) delay_rise <= (tout_r || meas_tout) ? '1 : CW'(sum_nxt >> LOG2_AVG);
      sum_r  <= sum_nxt;
      tout_r <= tout_r | meas_tout;
      trial  <= trial + LOG2_AVG'(1);
    end
  end
`else
  assign last_trial = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_fall <= '0;
      delay_rise <= '0;
    end else if (meas_exit) begin
      if (state == MEAS_F) delay_fall <= meas_val;
      else delay_rise <= meas_val;
    end
  end
`endif

endmodule

// File: tb/tb_inv_delay_meter.sv
// Directed bench for inv_delay_meter with a cycle-based inverter model on resp.
// Model delay d: resp shows the new level in the d-th cycle counting the launch cycle as 1.
module tb_inv_delay_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic        resp = 1'b1;
  logic        stim, busy, done, timeout, bad_init;
  logic [15:0] delay_fall, delay_rise;

  int n_cmp = 0;
  int n_fail = 0;
  int done_seen = 0;

  int   mode = 0;  // 0 model, 1 stuck high, 2 stuck low
  int   fall_dly = 5, rise_dly = 5;
  int   run = 100;
  logic last_stim = 1'b0;
  logic avg_mode = 1'b0;
  int   rise_idx = 0;
  int   fall_tab[4] = '{4, 5, 6, 7};

  inv_delay_meter #(
    .CW(16), .SETTLE_CYC(8), .MAX_CYC(1000), .SYNC_STG(2), .LOG2_AVG(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp(resp), .stim(stim),
    .busy(busy), .done(done), .delay_fall(delay_fall), .delay_rise(delay_rise),
    .timeout(timeout), .bad_init(bad_init)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_seen++;

  always @(posedge clk) begin
    if (stim === last_stim) begin
      if (run < 10000) run++;
    end else begin
      run = 1;
      if (stim === 1'b1 && avg_mode) begin
        fall_dly = fall_tab[rise_idx];
        if (rise_idx < 3) rise_idx++;
      end
    end
    last_stim = stim;
    #1;
    case (mode)
      1: resp = 1'b1;
      2: resp = 1'b0;
      default: begin
        if (last_stim && run >= fall_dly - 1) resp = 1'b0;
        else if (!last_stim && run >= rise_dly - 1) resp = 1'b1;
      end
    endcase
  end

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name, output int cyc);
    cyc = 0;
    n_cmp++;
    while (cyc < budget && done !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({stim, busy, done, timeout, bad_init} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {stim, busy, done, timeout, bad_init});
    end
    n_cmp++;
    if ({delay_fall, delay_rise} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_delays: got %h expected 00000000", {delay_fall, delay_rise});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_symmetric;
    int cyc, d0;
    mode = 0; fall_dly = 5; rise_dly = 5;
    repeat (10) @(negedge clk);
    d0 = done_seen;
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL sym_busy: got %b expected 1", busy); end
    wait_done(200, "sym_done", cyc);
    n_cmp++;
    if (delay_fall !== 16'd5) begin n_fail++; $display("FAIL sym_fall: got %0d expected 5", delay_fall); end
    n_cmp++;
    if (delay_rise !== 16'd5) begin n_fail++; $display("FAIL sym_rise: got %0d expected 5", delay_rise); end
    n_cmp++;
    if ({timeout, bad_init} !== 2'b00) begin n_fail++; $display("FAIL sym_flags: got %b expected 00", {timeout, bad_init}); end
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL sym_after: done,busy got %b expected 00", {done, busy}); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (done_seen - d0 !== 1) begin n_fail++; $display("FAIL sym_pulses: got %0d expected 1", done_seen - d0); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    mode = 0; fall_dly = 5; rise_dly = 5;
    pulse_start();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (stim !== 1'b1) begin n_fail++; $display("FAIL mid_in_meas: stim got %b expected 1", stim); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({stim, busy, done, timeout, bad_init} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_reset_flags: got %b expected 00000", {stim, busy, done, timeout, bad_init});
    end
    n_cmp++;
    if ({delay_fall, delay_rise} !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_delays: got %h expected 00000000", {delay_fall, delay_rise});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done(200, "mid_done", cyc);
    n_cmp++;
    if ({delay_fall, delay_rise} !== {16'd5, 16'd5}) begin
      n_fail++;
      $display("FAIL mid_remeasure: got %0d/%0d expected 5/5", delay_fall, delay_rise);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stuck_high;
    int cyc;
    mode = 1;
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done(1200, "stuck_done", cyc);
    n_cmp++;
    if (cyc !== 1017) begin n_fail++; $display("FAIL stuck_latency: got %0d cycles expected 1017", cyc); end
    n_cmp++;
    if (delay_fall !== 16'hFFFF) begin n_fail++; $display("FAIL stuck_fall: got %h expected FFFF", delay_fall); end
    n_cmp++;
    if (delay_rise !== 16'd0) begin n_fail++; $display("FAIL stuck_rise: got %0d expected 0", delay_rise); end
    n_cmp++;
    if ({timeout, bad_init} !== 2'b10) begin n_fail++; $display("FAIL stuck_flags: got %b expected 10", {timeout, bad_init}); end
    mode = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_asym;
    int cyc;
    mode = 0; fall_dly = 3; rise_dly = 9;
    repeat (10) @(negedge clk);
    pulse_start();
    wait_done(200, "asym_done", cyc);
    n_cmp++;
    if (delay_fall !== 16'd3) begin n_fail++; $display("FAIL asym_fall: got %0d expected 3", delay_fall); end
    n_cmp++;
    if (delay_rise !== 16'd9) begin n_fail++; $display("FAIL asym_rise: got %0d expected 9", delay_rise); end
    n_cmp++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL asym_timeout: got %b expected 0", timeout); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_bad_init_busy;
    int cyc, d0;
    mode = 2;
    repeat (3) @(negedge clk);
    d0 = done_seen;
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(1200, "badinit_done", cyc);
    n_cmp++;
    if (bad_init !== 1'b1) begin n_fail++; $display("FAIL badinit_flag: got %b expected 1", bad_init); end
    n_cmp++;
    if (delay_fall !== 16'd0) begin n_fail++; $display("FAIL badinit_fall_sat: got %0d expected 0", delay_fall); end
    n_cmp++;
    if ({delay_rise, timeout} !== {16'hFFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL badinit_rise: got %h/%b expected FFFF/1", delay_rise, timeout);
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_ignored: busy got %b expected 0", busy); end
    n_cmp++;
    if (done_seen - d0 !== 1) begin n_fail++; $display("FAIL busy_single_done: got %0d expected 1", done_seen - d0); end
    mode = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_flags_clear;
    int cyc;
    mode = 0; fall_dly = 4; rise_dly = 6;
    pulse_start();
    wait_done(200, "clear_done", cyc);
    n_cmp++;
    if ({delay_fall, delay_rise} !== {16'd4, 16'd6}) begin
      n_fail++;
      $display("FAIL clear_delays: got %0d/%0d expected 4/6", delay_fall, delay_rise);
    end
    n_cmp++;
    if ({timeout, bad_init} !== 2'b00) begin n_fail++; $display("FAIL clear_flags: got %b expected 00", {timeout, bad_init}); end
    repeat (5) @(negedge clk);
  endtask

`ifdef INVM_AVG_EN
  task automatic test_avg;
    int cyc, d0;
    mode = 0; rise_dly = 5; rise_idx = 0; avg_mode = 1'b1;
    repeat (10) @(negedge clk);
    d0 = done_seen;
    pulse_start();
    wait_done(600, "avg_done", cyc);
    n_cmp++;
    if ({delay_fall, delay_rise} !== {16'd5, 16'd5}) begin
      n_fail++;
      $display("FAIL avg_delays: got %0d/%0d expected 5/5", delay_fall, delay_rise);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (done_seen - d0 !== 1) begin n_fail++; $display("FAIL avg_single_done: got %0d expected 1", done_seen - d0); end
    avg_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_symmetric();
    test_reset_mid();
    test_stuck_high();
    test_asym();
    test_bad_init_busy();
    test_flags_clear();
`ifdef INVM_AVG_EN
    test_avg();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
